// File: rtl/calculator_arbiter_if.sv
// Bundles the two requester ports, the response port and the statistics
// counters of calculator_arbiter. The arbiter connects as slave, the
// requester/consumer side connects as master.
interface calculator_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic [1:0]            req0_op;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic [1:0]            req1_op;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic                  rsp_invalid;

  logic [CNT_WIDTH-1:0]  op_count;
  logic [CNT_WIDTH-1:0]  err_count;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_invalid,
    input  op_count, err_count
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_invalid,
    output op_count, err_count
  );
endinterface

// File: rtl/calculator_arbiter.sv
// Shares one combinational calculator between two requesters. A round-robin
// grant picks one requester in IDLE, its operands are latched, evaluated in
// EXEC and presented as a registered response in RESP until consumed.
// Saturating counters track completed and divide-by-zero responses.

module calculator #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [1:0]            op_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  invalid_o
);
  // ADD/SUB/MUL wrap to DATA_WIDTH bits; DIV by zero yields 0 and flags invalid
  always_comb begin
    result_o  = '0;
    invalid_o = 1'b0;
    case (op_i)
      2'b00: result_o = a_i + b_i;
      2'b01: result_o = a_i - b_i;
      2'b10: result_o = a_i * b_i;
      default: begin
        if (b_i == '0) begin
          invalid_o = 1'b1;
        end else begin
          result_o = a_i / b_i;
        end
      end
    endcase
  end
endmodule

module calculator_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  calculator_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state_q, state_d;
  logic                  lastGrant_q, lastGrant_d;
  logic [DATA_WIDTH-1:0] opA_q, opA_d;
  logic [DATA_WIDTH-1:0] opB_q, opB_d;
  logic [1:0]            opCode_q, opCode_d;
  logic                  opId_q, opId_d;
  logic                  rspId_q, rspId_d;
  logic [DATA_WIDTH-1:0] rspResult_q, rspResult_d;
  logic                  rspInvalid_q, rspInvalid_d;
  logic [CNT_WIDTH-1:0]  opCount_q, opCount_d;
  logic [CNT_WIDTH-1:0]  errCount_q, errCount_d;

  logic                  grantValid;
  logic                  grantId;
  logic                  req0Ready;
  logic                  req1Ready;
  logic [DATA_WIDTH-1:0] calcResult;
  logic                  calcInvalid;

  calculator #(.DATA_WIDTH(DATA_WIDTH)) calcInst (
    .a_i      (opA_q),
    .b_i      (opB_q),
    .op_i     (opCode_q),
    .result_o (calcResult),
    .invalid_o(calcInvalid)
  );

  // Round-robin pick: a lone requester wins, under contention the one not served last wins
  always_comb begin
    grantValid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grantId = ~lastGrant_q;
    end else begin
      grantId = bus.req1_valid;
    end
  end

  // Next-state and handshake logic; ready is only offered in IDLE and never during reset
  always_comb begin
    state_d      = state_q;
    lastGrant_d  = lastGrant_q;
    opA_d        = opA_q;
    opB_d        = opB_q;
    opCode_d     = opCode_q;
    opId_d       = opId_q;
    rspId_d      = rspId_q;
    rspResult_d  = rspResult_q;
    rspInvalid_d = rspInvalid_q;
    opCount_d    = opCount_q;
    errCount_d   = errCount_q;
    req0Ready    = 1'b0;
    req1Ready    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grantValid && !rst) begin
          if (grantId) begin
            req1Ready = 1'b1;
            opA_d     = bus.req1_a;
            opB_d     = bus.req1_b;
            opCode_d  = bus.req1_op;
          end else begin
            req0Ready = 1'b1;
            opA_d     = bus.req0_a;
            opB_d     = bus.req0_b;
            opCode_d  = bus.req0_op;
          end
          opId_d      = grantId;
          lastGrant_d = grantId;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        rspResult_d  = calcResult;
        rspInvalid_d = calcInvalid;
        rspId_d      = opId_q;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          if (opCount_q != '1) begin
            opCount_d = opCount_q + 1'b1;
          end
          if (rspInvalid_q && (errCount_q != '1)) begin
            errCount_d = errCount_q + 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset dropping any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lastGrant_q  <= 1'b1;
      opA_q        <= '0;
      opB_q        <= '0;
      opCode_q     <= '0;
      opId_q       <= 1'b0;
      rspId_q      <= 1'b0;
      rspResult_q  <= '0;
      rspInvalid_q <= 1'b0;
      opCount_q    <= '0;
      errCount_q   <= '0;
    end else begin
      state_q      <= state_d;
      lastGrant_q  <= lastGrant_d;
      opA_q        <= opA_d;
      opB_q        <= opB_d;
      opCode_q     <= opCode_d;
      opId_q       <= opId_d;
      rspId_q      <= rspId_d;
      rspResult_q  <= rspResult_d;
      rspInvalid_q <= rspInvalid_d;
      opCount_q    <= opCount_d;
      errCount_q   <= errCount_d;
    end
  end

  assign bus.req0_ready  = req0Ready;
  assign bus.req1_ready  = req1Ready;
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_id      = rspId_q;
  assign bus.rsp_result  = rspResult_q;
  assign bus.rsp_invalid = rspInvalid_q;
  assign bus.op_count    = opCount_q;
  assign bus.err_count   = errCount_q;
endmodule

// File: tb/tb_calculator_arbiter.sv
// Testbench for calculator_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_calculator_arbiter;
  localparam int DW = 16;
  localparam int CW = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  calculator_arbiter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  calculator_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Driven requester state
  bit          tValid[2];
  logic [DW-1:0] tA[2];
  logic [DW-1:0] tB[2];
  logic [1:0]  tOp[2];
  bit          accepted[2];
  bit          rspReadyDrv;

  // Reference model state
  bit          mBusy;
  int          mCycle;
  int          mRspAt;
  int          mLastGrant;
  logic        mRspId;
  logic [DW-1:0] mRspResult;
  logic        mRspInvalid;
  int          mOpCount;
  int          mErrCount;

  int grantLog[$];
  int rspIdLog[$];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Arithmetic reference computed with wide integers and explicit modulo
  task automatic calcRef(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] op,
                         output logic [DW-1:0] r, output logic inv);
    longint unsigned full;
    longint unsigned modulus;
    modulus = 64'd1 << DW;
    inv = 1'b0;
    full = 0;
    case (op)
      2'd0: full = longint'(a) + longint'(b);
      2'd1: full = longint'(a) + modulus - longint'(b);
      2'd2: full = longint'(a) * longint'(b);
      default: begin
        if (b == 0) inv = 1'b1;
        else full = longint'(a) / longint'(b);
      end
    endcase
    full = full % modulus;
    r = full[DW-1:0];
  endtask

  function automatic int pickGrant();
    if (tValid[0] && tValid[1]) return (mLastGrant == 0) ? 1 : 0;
    if (tValid[0]) return 0;
    if (tValid[1]) return 1;
    return -1;
  endfunction

  task automatic modelReset();
    mBusy = 0;
    mLastGrant = 1;
    mOpCount = 0;
    mErrCount = 0;
  endtask

  task automatic applyStimulus();
    bus.req0_valid = tValid[0];
    bus.req0_a     = tA[0];
    bus.req0_b     = tB[0];
    bus.req0_op    = tOp[0];
    bus.req1_valid = tValid[1];
    bus.req1_a     = tA[1];
    bus.req1_b     = tB[1];
    bus.req1_op    = tOp[1];
    bus.rsp_ready  = rspReadyDrv;
  endtask

  task automatic setReq(input int i, input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] op);
    tValid[i] = v;
    tA[i] = a;
    tB[i] = b;
    tOp[i] = op;
  endtask

  task automatic newOp(input int i);
    tOp[i] = 2'($urandom_range(0, 3));
    tA[i] = ($urandom_range(0, 1) == 1) ? DW'($urandom) : DW'($urandom_range(0, 300));
    case ($urandom_range(0, 3))
      0: tB[i] = '0;
      1: tB[i] = DW'($urandom_range(1, 20));
      default: tB[i] = DW'($urandom);
    endcase
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model at the rising edge
  task automatic stepCycle();
    int g;
    bit expectRsp;
    logic [DW-1:0] r;
    logic inv;
    applyStimulus();
    @(negedge clk);
    g = -1;
    if (!rst) begin
      if (!mBusy) g = pickGrant();
      checkOutput("req0_ready", 32'(bus.req0_ready), 32'(g == 0));
      checkOutput("req1_ready", 32'(bus.req1_ready), 32'(g == 1));
      if (bus.req0_ready) grantLog.push_back(0);
      if (bus.req1_ready) grantLog.push_back(1);
      expectRsp = mBusy && (mCycle >= mRspAt);
      checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(expectRsp));
      if (expectRsp) begin
        checkOutput("rsp_id", 32'(bus.rsp_id), 32'(mRspId));
        checkOutput("rsp_result", 32'(bus.rsp_result), 32'(mRspResult));
        checkOutput("rsp_invalid", 32'(bus.rsp_invalid), 32'(mRspInvalid));
      end
      checkOutput("op_count", 32'(bus.op_count), 32'(mOpCount));
      checkOutput("err_count", 32'(bus.err_count), 32'(mErrCount));
    end
    @(posedge clk);
    if (rst) begin
      modelReset();
    end else if (g >= 0) begin
      calcRef(tA[g], tB[g], tOp[g], r, inv);
      mRspId = g[0];
      mRspResult = r;
      mRspInvalid = inv;
      mBusy = 1;
      mRspAt = mCycle + 2;
      mLastGrant = g;
      accepted[g] = 1;
    end else if (mBusy && (mCycle >= mRspAt) && rspReadyDrv) begin
      if (mOpCount < CNT_MAX) mOpCount++;
      if (mRspInvalid && (mErrCount < CNT_MAX)) mErrCount++;
      rspIdLog.push_back(int'(mRspId));
      mBusy = 0;
    end
    mCycle++;
    #1;
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) stepCycle();
  endtask

  initial begin
    $display("[TB] starting calculator_arbiter test");
    modelReset();
    mCycle = 0;
    mRspAt = 0;
    mRspId = 1'b0;
    mRspResult = '0;
    mRspInvalid = 1'b0;
    rspReadyDrv = 1;
    setReq(0, 0, '0, '0, 2'd0);
    setReq(1, 0, '0, '0, 2'd0);
    accepted[0] = 0;
    accepted[1] = 0;

    // Reset and reset values
    rst = 1;
    runCycles(2);
    rst = 0;
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    checkOutput("reset_rsp_result", 32'(bus.rsp_result), 32'd0);
    checkOutput("reset_rsp_invalid", 32'(bus.rsp_invalid), 32'd0);
    checkOutput("reset_op_count", 32'(bus.op_count), 32'd0);
    checkOutput("reset_err_count", 32'(bus.err_count), 32'd0);

    // Single add from requester 0
    setReq(0, 1, 16'd7, 16'd5, 2'd0);
    stepCycle();
    tValid[0] = 0;
    stepCycle();
    checkOutput("add_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("add_rsp_id", 32'(bus.rsp_id), 32'd0);
    checkOutput("add_result", 32'(bus.rsp_result), 32'd12);
    checkOutput("add_invalid", 32'(bus.rsp_invalid), 32'd0);
    stepCycle();
    checkOutput("add_op_count", 32'(bus.op_count), 32'd1);

    // Wrapping sub and mul from requester 1
    setReq(1, 1, 16'd3, 16'd5, 2'd1);
    stepCycle();
    tValid[1] = 0;
    stepCycle();
    checkOutput("sub_result", 32'(bus.rsp_result), 32'hFFFE);
    checkOutput("sub_rsp_id", 32'(bus.rsp_id), 32'd1);
    stepCycle();
    setReq(1, 1, 16'h0100, 16'h0100, 2'd2);
    stepCycle();
    tValid[1] = 0;
    stepCycle();
    checkOutput("mul_result", 32'(bus.rsp_result), 32'd0);
    stepCycle();

    // Divide and divide-by-zero
    setReq(0, 1, 16'd100, 16'd7, 2'd3);
    stepCycle();
    tValid[0] = 0;
    stepCycle();
    checkOutput("div_result", 32'(bus.rsp_result), 32'd14);
    stepCycle();
    setReq(0, 1, 16'd100, 16'd0, 2'd3);
    stepCycle();
    tValid[0] = 0;
    stepCycle();
    checkOutput("div0_result", 32'(bus.rsp_result), 32'd0);
    checkOutput("div0_invalid", 32'(bus.rsp_invalid), 32'd1);
    stepCycle();
    checkOutput("div0_err_count", 32'(bus.err_count), 32'd1);
    checkOutput("div0_op_count", 32'(bus.op_count), 32'd5);

    // Backpressure with requester 1 waiting
    setReq(0, 1, 16'd9, 16'd3, 2'd2);
    stepCycle();
    tValid[0] = 0;
    rspReadyDrv = 0;
    setReq(1, 1, 16'd40, 16'd2, 2'd3);
    stepCycle();
    runCycles(10);
    checkOutput("bp_result", 32'(bus.rsp_result), 32'd27);
    checkOutput("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
    rspReadyDrv = 1;
    stepCycle();
    checkOutput("bp_release_req1_ready", 32'(bus.req1_ready), 32'd1);
    stepCycle();
    tValid[1] = 0;
    runCycles(2);

    // Reset during EXEC drops the operation
    setReq(0, 1, 16'd5, 16'd5, 2'd0);
    stepCycle();
    tValid[0] = 0;
    rst = 1;
    stepCycle();
    rst = 0;
    checkOutput("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("midrst_op_count", 32'(bus.op_count), 32'd0);
    checkOutput("midrst_err_count", 32'(bus.err_count), 32'd0);

    // Continuous contention after reset: grants alternate starting with 0
    grantLog.delete();
    rspIdLog.delete();
    setReq(0, 1, 16'd1, 16'd1, 2'd0);
    setReq(1, 1, 16'd2, 16'd2, 2'd0);
    applyStimulus();
    #1;
    checkOutput("contend_first_req0_ready", 32'(bus.req0_ready), 32'd1);
    runCycles(12);
    checkOutput("contend_grant_count", 32'(grantLog.size()), 32'd4);
    checkOutput("contend_rsp_count", 32'(rspIdLog.size()), 32'd4);
    if (grantLog.size() >= 4 && rspIdLog.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput("contend_grant_order", 32'(grantLog[k]), 32'(k % 2));
        checkOutput("contend_rsp_id_order", 32'(rspIdLog[k]), 32'(k % 2));
      end
    end

    // Random traffic with withdrawals and backpressure
    accepted[0] = 0;
    accepted[1] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (accepted[i]) begin
          accepted[i] = 0;
          tValid[i] = ($urandom_range(0, 3) != 0);
          newOp(i);
        end else if (tValid[i]) begin
          if ($urandom_range(0, 9) == 0) tValid[i] = 0;
        end else if ($urandom_range(0, 1) == 1) begin
          tValid[i] = 1;
          newOp(i);
        end
      end
      rspReadyDrv = ($urandom_range(0, 9) < 7);
      stepCycle();
    end

    // Drive both counters into saturation with back-to-back divide-by-zero
    setReq(0, 1, 16'd1, 16'd0, 2'd3);
    setReq(1, 1, 16'd2, 16'd0, 2'd3);
    rspReadyDrv = 1;
    runCycles(900);
    checkOutput("sat_op_count", 32'(bus.op_count), 32'(CNT_MAX));
    checkOutput("sat_err_count", 32'(bus.err_count), 32'(CNT_MAX));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
